// File: rtl/conv_interleaver.sv
// conv_interleaver: convolutional (de)interleaver with per-branch shift registers, sync
// alignment, priming flag and resync detection.
module conv_interleaver #(
   parameter int WIDTH      = 8,
   parameter int BRANCHES   = 12,
   parameter int UNIT_DEPTH = 17
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        buf_en,
   input  logic                        sync,
   input  logic                        mode,
   input  logic [WIDTH-1:0]            data_in,
   output logic [WIDTH-1:0]            data_out,
   output logic                        out_valid,
   output logic [$clog2(BRANCHES)-1:0] branch_idx,
   output logic                        primed,
   output logic                        sync_err
);
   localparam int BW = $clog2(BRANCHES);
   localparam int L  = (BRANCHES - 1) * UNIT_DEPTH * BRANCHES;
   localparam int CW = $clog2(L + 1);

   logic             sy, clr, mode_q, mode_d, out_valid_q, out_valid_d;
   logic             primed_q, primed_d, sync_err_q, sync_err_d;
   logic [BW-1:0]    sel, branch_idx_q, branch_idx_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] tap [BRANCHES];

   // ext holds data_in at entry 0, so tap entry D is the byte D selections back on this branch
   for (genvar g = 0; g < BRANCHES; g++) begin : g_br
      localparam int DI = g * UNIT_DEPTH;
      localparam int DD = (BRANCHES - 1 - g) * UNIT_DEPTH;
      localparam int S  = DI > DD ? DI : DD;
      logic [S*WIDTH-1:0]     sr_q, sr_d;
      logic [(S+1)*WIDTH-1:0] ext;
      assign ext    = {sr_q, data_in};
      assign sr_d   = ext[S*WIDTH-1:0];
      assign tap[g] = mode_d ? ext[DD*WIDTH +: WIDTH] : ext[DI*WIDTH +: WIDTH];
      always_ff @(posedge clk or posedge reset)
         if (reset) sr_q <= '0;
         else if (buf_en && sel == BW'(g)) sr_q <= sr_d;
   end

   always_comb begin
      sy           = buf_en & sync;
      sel          = sy ? '0 : branch_idx_q;
      mode_d       = sy ? mode : mode_q;
      branch_idx_d = buf_en ? (sel == BW'(BRANCHES - 1) ? '0 : sel + 1'b1) : branch_idx_q;
      clr          = sy && (branch_idx_q != '0 || mode != mode_q);
      cnt_base     = clr ? '0 : cnt_q;
      cnt_d        = buf_en ? (cnt_base == CW'(L) ? cnt_base : cnt_base + 1'b1) : cnt_q;
      primed_d     = buf_en ? cnt_base == CW'(L) : primed_q;
      data_out_d   = buf_en ? tap[sel] : data_out_q;
      out_valid_d  = buf_en;
      sync_err_d   = sy && branch_idx_q != '0;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         branch_idx_q <= '0;
         mode_q       <= 1'b0;
         cnt_q        <= '0;
         primed_q     <= 1'b0;
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         branch_idx_q <= branch_idx_d;
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         primed_q     <= primed_d;
         data_out_q   <= data_out_d;
         out_valid_q  <= out_valid_d;
         sync_err_q   <= sync_err_d;
      end

   assign data_out   = data_out_q;
   assign out_valid  = out_valid_q;
   assign branch_idx = branch_idx_q;
   assign primed     = primed_q;
   assign sync_err   = sync_err_q;
endmodule

// File: tb/tb_conv_interleaver.sv
// tb_conv_interleaver: directed checks of a B=3/M=2 and a B=12/M=17 interleave->deinterleave chain.
module tb_conv_interleaver;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   logic       en_a = 0, sync_a = 0, mode_a = 0, sync_b = 0;
   logic [7:0] din_a = 0, dout_a, dout_b;
   logic       ov_a, ov_b, pr_a, pr_b, se_a, se_b;
   logic [1:0] idx_a, idx_b;
   logic       en_c = 0, sync_c = 0, mode_c = 0, sync_d = 0;
   logic [7:0] din_c = 0, dout_c, dout_d;
   logic       ov_c, ov_d, pr_c, pr_d, se_c, se_d;
   logic [3:0] idx_c, idx_d;

   conv_interleaver #(.WIDTH(8), .BRANCHES(3), .UNIT_DEPTH(2)) u_a (.clk(clk), .reset(reset),
      .buf_en(en_a), .sync(sync_a), .mode(mode_a), .data_in(din_a), .data_out(dout_a),
      .out_valid(ov_a), .branch_idx(idx_a), .primed(pr_a), .sync_err(se_a));
   conv_interleaver #(.WIDTH(8), .BRANCHES(3), .UNIT_DEPTH(2)) u_b (.clk(clk), .reset(reset),
      .buf_en(ov_a), .sync(sync_b), .mode(1'b1), .data_in(dout_a), .data_out(dout_b),
      .out_valid(ov_b), .branch_idx(idx_b), .primed(pr_b), .sync_err(se_b));
   conv_interleaver #(.WIDTH(8), .BRANCHES(12), .UNIT_DEPTH(17)) u_c (.clk(clk), .reset(reset),
      .buf_en(en_c), .sync(sync_c), .mode(mode_c), .data_in(din_c), .data_out(dout_c),
      .out_valid(ov_c), .branch_idx(idx_c), .primed(pr_c), .sync_err(se_c));
   conv_interleaver #(.WIDTH(8), .BRANCHES(12), .UNIT_DEPTH(17)) u_d (.clk(clk), .reset(reset),
      .buf_en(ov_c), .sync(sync_d), .mode(1'b1), .data_in(dout_c), .data_out(dout_d),
      .out_valid(ov_d), .branch_idx(idx_d), .primed(pr_d), .sync_err(se_d));

   // the second stage of each chain sees the sync alongside the first stage's output
   always @(posedge clk) begin
      sync_b <= en_a & sync_a;
      sync_d <= en_c & sync_c;
   end

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step_a(input logic en, input logic sy, input logic md, input logic [7:0] d);
      en_a = en; sync_a = sy; mode_a = md; din_a = d;
      @(posedge clk); #1;
   endtask

   task automatic step_c(input logic en, input logic sy, input logic [7:0] d);
      en_c = en; sync_c = sy; din_c = d;
      @(posedge clk); #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_dout_a"}, dout_a, 0); chk({tag, "_ov_a"}, ov_a, 0);
      chk({tag, "_pr_a"}, pr_a, 0);     chk({tag, "_se_a"}, se_a, 0);
      chk({tag, "_idx_a"}, idx_a, 0);   chk({tag, "_dout_c"}, dout_c, 0);
      chk({tag, "_ov_c"}, ov_c, 0);     chk({tag, "_pr_c"}, pr_c, 0);
      chk({tag, "_idx_c"}, idx_c, 0);
   endtask

   initial begin
      int exp_i [15] = '{1, 0, 0, 4, 0, 0, 7, 2, 0, 10, 5, 0, 13, 8, 3};
      logic [7:0] in_q [$];
      int sent, dj;
      logic e;
      @(posedge clk); #1;
      chk_zero("reset");
      reset = 0;
      for (int n = 1; n <= 40; n++) begin
         step_a(1, n == 1, 0, 8'(n));
         chk("il_ov", ov_a, 1);
         if (n <= 15) begin
            chk($sformatf("il_data%0d", n), dout_a, exp_i[n-1]);
            chk($sformatf("il_primed%0d", n), pr_a, n >= 13);
         end
         if (n >= 2) begin
            chk($sformatf("chain_data%0d", n), dout_b, n > 13 ? n - 13 : 0);
            chk($sformatf("chain_primed%0d", n), pr_b, n >= 14);
         end
      end
      step_a(0, 0, 0, 8'd0);
      chk("idle_ov", ov_a, 0);
      chk("idle_hold", dout_a, 40);
      chk("idle_idx", idx_a, 1);
      chk("idle_primed", pr_a, 1);
      chk("chain_last", dout_b, 28);
      chk("chain_last_primed", pr_b, 1);
      step_a(1, 0, 0, 8'd41);
      chk("b41", dout_a, 35);
      step_a(1, 0, 0, 8'd42);
      chk("b42", dout_a, 30);
      chk("idx_wrap", idx_a, 0);
      step_a(1, 1, 1, 8'd77);
      chk("modesw_data", dout_a, 31);
      chk("modesw_primed", pr_a, 0);
      chk("modesw_se", se_a, 0);
      chk("modesw_idx", idx_a, 1);
      step_a(1, 1, 1, 8'd99);
      chk("resync_data", dout_a, 34);
      chk("resync_se", se_a, 1);
      chk("resync_idx", idx_a, 1);
      step_a(0, 1, 1, 8'd0);
      chk("se_pulse_end", se_a, 0);
      chk("sync_no_en_idx", idx_a, 1);
      for (int k = 1; k <= 12; k++) begin
         step_a(1, 0, 1, 8'(k));
         if (k >= 11) chk($sformatf("reprime%0d", k), pr_a, k == 12);
      end
      step_a(0, 0, 0, 8'd0);
      sent = 0; dj = 0;
      while (sent < 3000) begin
         e = sent == 0 ? 1'b1 : 1'($urandom_range(1));
         step_c(e, sent == 0, 8'($urandom));
         if (e) begin in_q.push_back(din_c); sent++; end
         chk("gap_ov", ov_c, e);
         if (ov_d) begin
            dj++;
            chk($sformatf("gap_chain%0d", dj), dout_d, dj > 2244 ? in_q[dj-2245] : 0);
         end
      end
      chk("gap_primed", pr_c, 1);
      chk("gap_idx", idx_c, 0);
      for (int k = 0; k < 4; k++) step_c(1, 0, 8'(k));
      chk("pre_resync_idx", idx_c, 4);
      step_c(1, 1, 8'hA5);
      chk("big_resync_data", dout_c, 8'hA5);
      chk("big_resync_idx", idx_c, 1);
      chk("big_resync_se", se_c, 1);
      chk("big_resync_primed", pr_c, 0);
      step_c(0, 0, 8'd0);
      chk("big_se_end", se_c, 0);
      for (int k = 1; k <= 2243; k++) step_c(1, 0, 8'(k));
      chk("big_reprime_early", pr_c, 0);
      step_c(1, 0, 8'd1);
      chk("big_reprime", pr_c, 1);
      en_c = 1; en_a = 1; din_a = 8'd9; mode_a = 1;
      #2 reset = 1;
      #1 chk_zero("midreset");
      en_c = 0; en_a = 0;
      @(posedge clk); #1;
      chk_zero("midreset_hold");
      reset = 0;
      step_a(1, 0, 0, 8'd5);
      chk("post_reset_b0", dout_a, 5);
      chk("post_reset_idx", idx_a, 1);
      step_a(1, 0, 0, 8'd6);
      chk("post_reset_b1", dout_a, 0);
      step_a(1, 0, 0, 8'd7);
      chk("post_reset_b2", dout_a, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conv_interleaver.md
# conv_interleaver

Parametrised convolutional interleaver/deinterleaver for the outer-code byte stream. It has BRANCHES branch delay lines; branch i holds a multiple of UNIT_DEPTH entries. An input commutator and an output commutator step one branch per accepted byte. A mode bit selects interleave (branch depth i·UNIT_DEPTH) or deinterleave (depth (BRANCHES-1-i)·UNIT_DEPTH). This block replaces the fixed-depth hand-chained branch buffers with one configurable engine, and adds sync alignment, a priming flag and resync detection.

## Interface
- WIDTH, 8, symbol width in bits
- BRANCHES, 12, number of branches (≥2)
- UNIT_DEPTH, 17, depth increment per branch (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- buf_en  in  1  input byte valid; a byte is accepted on each clk edge with buf_en=1
- sync  in  1  qualifies data_in as frame start; meaningful only with buf_en=1
- mode  in  1  0=interleave, 1=deinterleave; sampled only on accepted sync bytes
- data_in  in  WIDTH  input symbol
- data_out  out  WIDTH  output symbol, registered
- out_valid  out  1  data_out valid; buf_en delayed 1 cycle
- branch_idx  out  clog2(BRANCHES)  branch the next accepted byte will use
- primed  out  1  data_out carries real data, not reset filler
- sync_err  out  1  one-cycle pulse: sync received while branch_idx≠0

## Operation
- Branch storage: branch i sized max(i, BRANCHES-1-i)·UNIT_DEPTH entries. The active depth is tap-selected by mode_q.
  - Interleave: D(i)=i·UNIT_DEPTH.
  - Deinterleave: D(i)=(BRANCHES-1-i)·UNIT_DEPTH.
- Per accepted byte on branch k: branch k shifts data_in in. The output is the byte that entered branch k D(k) selections earlier.
  - D(k)=0: output equals data_in.
  - Before D(k) prior entries exist, the output is the reset content 0.
- Only the selected branch shifts. Other branches hold their contents. With buf_en=0 nothing shifts or advances.
- Commutator: branch_idx increments per accepted byte and wraps BRANCHES-1→0.
- Sync handling: an accepted byte with sync=1 is forced to branch 0 regardless of branch_idx, and branch_idx becomes 1 afterwards (0 if BRANCHES=1 is excluded; BRANCHES≥2).
  - mode is sampled into mode_q on that same edge and applies to that byte.
  - If branch_idx≠0 at sync, sync_err pulses on the next cycle and prime_cnt clears.
  - Storage is never cleared by sync or a mode change.
  - If mode differs from mode_q at sync, prime_cnt clears.
- Priming: prime_cnt counts accepted bytes and saturates at L=(BRANCHES-1)·UNIT_DEPTH·BRANCHES.
  - primed=1 on the output of accepted byte number L+1 onward, counted since reset or since the last clear.
  - The counter clears at reset, on a resync, or on a mode change.
- Chained interleave→deinterleave instances reproduce the input stream delayed exactly L accepted bytes.

## Timing
- Latency: data_out/out_valid update 1 clk after the accepting edge. data_out holds its value when out_valid=0.
- Reset values (asynchronous):
  - data_out=0, out_valid=0, primed=0, sync_err=0
  - branch_idx=0, mode_q=0, all storage=0
- Reset mid-stream discards everything. The first accepted byte after reset goes to branch 0.
- Simultaneous events:
  - sync on the byte where branch_idx is already 0: normal operation, no sync_err.
  - sync with buf_en=0: ignored.
- Throughput: one byte per clk, sustained. Gaps in buf_en are arbitrary.
- Counter widths: branch_idx is clog2(BRANCHES); prime_cnt is clog2(L+1). No overflow beyond saturation.

## Test plan
- Reset/idle: assert reset mid-run, hold buf_en=0 → every output 0, branch_idx=0, no shifts.
- Interleave ordering (B=3, M=2, mode=0): sync on byte 1, stream 1..15 continuous.
  - Required data_out: 1,0,0,4,0,0,7,2,0,10,5,0,13,8,3.
  - primed first high with the output 13.
- Deinterleave + chain (B=3, M=2): interleaver feeds a mode=1 instance, input 1..40 → second output equals input delayed 12 bytes. Second instance primed after 12 accepted bytes.
- Gapped input (B=12, M=17): buf_en random 50%, 3000 bytes, interleave→deinterleave chain → output is the exact input delayed by 2244 accepted bytes. out_valid tracks buf_en with 1-cycle delay.
- Resync (B=12, M=17): sync asserted on the 5th byte of a frame.
  - The byte goes to branch 0, branch_idx becomes 1.
  - sync_err is a 1-cycle pulse; primed drops and re-asserts after 2244 more bytes.
- Mode switch: primed interleaver, sync with mode=1 → primed clears, new depths apply from that byte, no sync_err if branch_idx was 0.
